// File: rtl/fetch_sequencer.sv
// fetch_sequencer: word-PC fetch/execute sequencer for the 32-word RV32I lab core.
// Defining FETCH_PERF_EN adds a saturating retired-instruction counter on retired_count.
module fetch_sequencer #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_mode,
  input  logic              step_pulse,
  input  logic [31:0]       instr_in,
  input  logic              branch_eq,
  output logic [ADDR_W-1:0] pc_address,
  output logic              imem_enable,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  output logic              halted,
  output logic              fault,
  output logic [15:0]       retired_count
);

  // Halfword-granular offset: bit 0 flags a misaligned target, the rest is the word offset
  localparam int unsigned HW_W       = ADDR_W + 1;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [2:0]  F3_BEQ     = 3'b000;
  localparam logic [2:0]  F3_BNE     = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_HALT
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [HW_W-1:0]   imm_hw;
  logic [ADDR_W-1:0] word_off;
  logic              is_jal;
  logic              is_branch;
  logic              taken;
  logic              self_loop;
  logic              misaligned;
  logic              halt_c;
  logic              imem_enable_d;
  logic              instr_valid_d;
  logic              halted_d;

  // Redirect decode of the latched instruction, used only while in EXEC
  always_comb begin
    is_jal    = (instr_out[6:0] == OPC_JAL);
    is_branch = (instr_out[6:0] == OPC_BRANCH);
    taken     = is_jal ||
                (is_branch && (((instr_out[14:12] == F3_BEQ) && branch_eq) ||
                               ((instr_out[14:12] == F3_BNE) && !branch_eq)));
    if (is_jal) begin
      imm_hw = HW_W'({{12{instr_out[31]}}, instr_out[31], instr_out[19:12],
                      instr_out[20], instr_out[30:21]});
    end else begin
      imm_hw = HW_W'({{20{instr_out[31]}}, instr_out[31], instr_out[7],
                      instr_out[30:25], instr_out[11:8]});
    end
    word_off   = imm_hw[HW_W-1:1];
    self_loop  = taken && (word_off == '0);
    misaligned = taken && imm_hw[0];
    halt_c     = self_loop || misaligned;
    pc_next    = pc + ADDR_W'(1);
    if (halt_c) begin
      pc_next = pc;
    end else if (taken) begin
      pc_next = pc + word_off;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; step requests outside IDLE/WAIT are dropped
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (run_mode || step_pulse) state_next = S_FETCH;
      S_FETCH: state_next = S_EXEC;
      S_EXEC: begin
        if (halt_c) begin
          state_next = S_HALT;
        end else if (run_mode) begin
          state_next = S_FETCH;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_WAIT:  if (run_mode || step_pulse) state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the strobes come straight off flops
  always_comb begin
    imem_enable_d = 1'b0;
    instr_valid_d = 1'b0;
    halted_d      = 1'b0;
    case (state_next)
      S_FETCH: imem_enable_d = 1'b1;
      S_EXEC:  instr_valid_d = 1'b1;
      S_HALT:  halted_d      = 1'b1;
      default: ;
    endcase
  end

  // PC, instruction register and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= ADDR_W'(RESET_PC);
      instr_out   <= NOP_INSTR;
      imem_enable <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      imem_enable <= imem_enable_d;
      instr_valid <= instr_valid_d;
      halted      <= halted_d;
      if (state == S_FETCH) begin
        instr_out <= instr_in;
      end
      if (state == S_EXEC) begin
        pc <= pc_next;
        if (misaligned) begin
          fault <= 1'b1;
        end
      end
    end
  end

  assign pc_address = pc;

`ifdef FETCH_PERF_EN
  logic [15:0] retired_q;

  // Saturating count of EXEC cycles, halting instruction included
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= 16'd0;
    end else if ((state == S_EXEC) && (retired_q != 16'hFFFF)) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign retired_count = retired_q;
`else
  assign retired_count = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer with a 32-word instruction memory model.
// Build with FETCH_PERF_EN defined to also exercise the retired-instruction counter.
module tb_fetch_sequencer;

  localparam int unsigned ADDR_W = 5;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              run_mode;
  logic              step_pulse;
  logic [31:0]       instr_in;
  logic              branch_eq;
  logic [ADDR_W-1:0] pc_address;
  logic              imem_enable;
  logic [31:0]       instr_out;
  logic              instr_valid;
  logic              halted;
  logic              fault;
  logic [15:0]       retired_count;

  logic [31:0] mem [32];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign instr_in = mem[pc_address];

  fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .run_mode     (run_mode),
    .step_pulse   (step_pulse),
    .instr_in     (instr_in),
    .branch_eq    (branch_eq),
    .pc_address   (pc_address),
    .imem_enable  (imem_enable),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .halted       (halted),
    .fault        (fault),
    .retired_count(retired_count)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0013;
  endtask

  // Reset for two cycles, then release with the requested mode
  task automatic start(input logic rm);
    reset      = 1'b1;
    run_mode   = 1'b0;
    step_pulse = 1'b0;
    tick();
    tick();
    reset    = 1'b0;
    run_mode = rm;
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < budget) begin
      tick();
      n++;
      if (instr_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    run_mode   = 1'b1;
    step_pulse = 1'b1;
    branch_eq  = 1'b0;
    clear_mem();
    tick();
    tick();
    total++;
    if (pc_address !== 5'd0) begin
      bad++; $display("FAIL reset_pc: got %0d want 0", pc_address);
    end
    total++;
    if (instr_out !== 32'h0000_0013) begin
      bad++; $display("FAIL reset_instr: got %h want 00000013", instr_out);
    end
    total++;
    if (instr_valid !== 1'b0 || imem_enable !== 1'b0) begin
      bad++; $display("FAIL reset_strobes: got valid=%b en=%b want 0 0", instr_valid, imem_enable);
    end
    total++;
    if (halted !== 1'b0 || fault !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got halted=%b fault=%b want 0 0", halted, fault);
    end
    total++;
    if (retired_count !== 16'd0) begin
      bad++; $display("FAIL reset_retired: got %0d want 0", retired_count);
    end
    step_pulse = 1'b0;
  endtask

  task automatic test_lab_run();
    int exp_pc [7] = '{0, 1, 2, 3, 4, 5, 11};
    bit ok;
    int n;
    clear_mem();
    mem[0]  = 32'h00A0_0513;
    mem[1]  = 32'h0010_0593;
    mem[2]  = 32'h0020_0613;
    mem[3]  = 32'h0030_0693;
    mem[4]  = 32'h0040_0713;
    mem[5]  = 32'h0180_006F;
    mem[11] = 32'h0000_006F;
    start(1'b1);
    tick();
    total++;
    if (imem_enable !== 1'b1 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL lab_fetch1: got en=%b valid=%b want 1 0", imem_enable, instr_valid);
    end
    tick();
    total++;
    if (instr_valid !== 1'b1 || instr_out !== 32'h00A0_0513 || pc_address !== 5'd0) begin
      bad++; $display("FAIL lab_exec1: got valid=%b instr=%h pc=%0d want 1 00a00513 0",
                      instr_valid, instr_out, pc_address);
    end
    for (int k = 1; k < 7; k++) begin
      wait_valid(4, ok, n);
      total++;
      if (!ok || n != 2 || int'(pc_address) != exp_pc[k]) begin
        bad++; $display("FAIL lab_pc%0d: got ok=%b gap=%0d pc=%0d want 1 2 %0d",
                        k, ok, n, pc_address, exp_pc[k]);
      end
    end
    tick();
    total++;
    if (halted !== 1'b1 || fault !== 1'b0 || pc_address !== 5'd11 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL lab_halt: got halted=%b fault=%b pc=%0d valid=%b want 1 0 11 0",
                      halted, fault, pc_address, instr_valid);
    end
    total++;
    if (retired_count !== (PERF ? 16'd7 : 16'd0)) begin
      bad++; $display("FAIL lab_retired: got %0d want %0d", retired_count, PERF ? 7 : 0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (retired_count !== 16'd0 || halted !== 1'b0) begin
      bad++; $display("FAIL lab_clear: got retired=%0d halted=%b want 0 0", retired_count, halted);
    end
  endtask

  task automatic test_branch();
    logic [31:0] vi [5] = '{32'hFE52_02E3, 32'hFE52_02E3, 32'hFE52_12E3, 32'hFE52_12E3, 32'hFE52_42E3};
    logic        ve [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int          vp [5] = '{6, 14, 6, 14, 14};
    bit ok;
    int n;
    for (int v = 0; v < 5; v++) begin
      clear_mem();
      mem[0]  = 32'h0340_006F;
      mem[13] = vi[v];
      mem[6]  = 32'h0000_006F;
      mem[14] = 32'h0000_006F;
      branch_eq = ve[v];
      start(1'b1);
      wait_valid(4, ok, n);
      wait_valid(4, ok, n);
      total++;
      if (!ok || pc_address !== 5'd13) begin
        bad++; $display("FAIL br%0d_reach: got ok=%b pc=%0d want 1 13", v, ok, pc_address);
      end
      tick();
      total++;
      if (int'(pc_address) != vp[v] || halted !== 1'b0) begin
        bad++; $display("FAIL br%0d_target: got pc=%0d halted=%b want %0d 0",
                        v, pc_address, halted, vp[v]);
      end
    end
    branch_eq = 1'b0;
  endtask

  task automatic test_step();
    int cnt;
    int hold;
    clear_mem();
    start(1'b0);
    tick();
    tick();
    tick();
    total++;
    if (imem_enable !== 1'b0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL step_idle: got en=%b valid=%b want 0 0", imem_enable, instr_valid);
    end
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      hold = (k == 2) ? 3 : 1;
      step_pulse = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (i + 1 == hold) step_pulse = 1'b0;
        if (instr_valid) begin
          cnt++;
          total++;
          if (i != 1) begin
            bad++; $display("FAIL step%0d_latency: got cycle %0d want 1", k, i);
          end
        end
      end
    end
    total++;
    if (cnt != 3 || pc_address !== 5'd3) begin
      bad++; $display("FAIL step_count: got count=%0d pc=%0d want 3 3", cnt, pc_address);
    end
  endtask

  task automatic test_wrap();
    int exp_pc [4] = '{0, 31, 0, 31};
    bit ok;
    int n;
    clear_mem();
    mem[0] = 32'hFFDF_F06F;
    start(1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_valid(4, ok, n);
      total++;
      if (!ok || int'(pc_address) != exp_pc[k]) begin
        bad++; $display("FAIL wrap%0d: got ok=%b pc=%0d want 1 %0d", k, ok, pc_address, exp_pc[k]);
      end
    end
    tick();
    total++;
    if (halted !== 1'b0 || pc_address !== 5'd0) begin
      bad++; $display("FAIL wrap_end: got halted=%b pc=%0d want 0 0", halted, pc_address);
    end
  endtask

  task automatic test_halt();
    bit ok;
    int n;
    int seen;
    clear_mem();
    mem[0] = 32'h01C0_006F;
    mem[7] = 32'h0000_006F;
    start(1'b1);
    wait_valid(4, ok, n);
    wait_valid(4, ok, n);
    total++;
    if (!ok || pc_address !== 5'd7) begin
      bad++; $display("FAIL halt_exec: got ok=%b pc=%0d want 1 7", ok, pc_address);
    end
    tick();
    total++;
    if (halted !== 1'b1 || fault !== 1'b0 || pc_address !== 5'd7) begin
      bad++; $display("FAIL halt_loop: got halted=%b fault=%b pc=%0d want 1 0 7", halted, fault, pc_address);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step_pulse = (i % 2 == 0);
      run_mode   = (i % 3 != 0);
      tick();
      if (instr_valid || imem_enable || !halted || pc_address != 5'd7) seen++;
    end
    step_pulse = 1'b0;
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL halt_sticky: got %0d disturbed cycles want 0", seen);
    end
    mem[7] = 32'h0020_006F;
    start(1'b1);
    wait_valid(4, ok, n);
    wait_valid(4, ok, n);
    tick();
    total++;
    if (!ok || halted !== 1'b1 || fault !== 1'b1 || pc_address !== 5'd7) begin
      bad++; $display("FAIL halt_misaligned: got ok=%b halted=%b fault=%b pc=%0d want 1 1 1 7",
                      ok, halted, fault, pc_address);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    int guard;
    clear_mem();
    start(1'b1);
    ok = 1'b0;
    guard = 0;
    while (guard < 6 && !(ok && pc_address == 5'd4)) begin
      wait_valid(4, ok, n);
      guard++;
    end
    total++;
    if (!ok || pc_address !== 5'd4 || retired_count !== (PERF ? 16'd4 : 16'd0)) begin
      bad++; $display("FAIL mid_reach: got ok=%b pc=%0d retired=%0d want 1 4 %0d",
                      ok, pc_address, retired_count, PERF ? 4 : 0);
    end
    reset = 1'b1;
    tick();
    total++;
    if (pc_address !== 5'd0 || instr_valid !== 1'b0 || imem_enable !== 1'b0 || retired_count !== 16'd0) begin
      bad++; $display("FAIL mid_reset: got pc=%0d valid=%b en=%b retired=%0d want 0 0 0 0",
                      pc_address, instr_valid, imem_enable, retired_count);
    end
    run_mode = 1'b0;
    reset    = 1'b0;
    tick();
    tick();
    total++;
    if (imem_enable !== 1'b0 || instr_valid !== 1'b0 || pc_address !== 5'd0) begin
      bad++; $display("FAIL mid_idle: got en=%b valid=%b pc=%0d want 0 0 0",
                      imem_enable, instr_valid, pc_address);
    end
  endtask

  initial begin
    test_reset();
    test_lab_run();
    test_branch();
    test_step();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
